// File: rtl/receive.sv
// 8N1 UART receiver: oversampled start validation, mid-bit sampling, byte held for the bus.
// Latency: rda rises on the STOP sample tick, OVERSAMPLE/2 + 9*OVERSAMPLE ticks after start detect.
// No backpressure: an unread byte is overwritten by the next frame and oe is raised.
module receive #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       brg_rx_en,
    input  logic       rxd,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    output logic [7:0] rx_buf,
    output logic       rda,
    output logic       fe,
    output logic       oe
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] MID_CNT  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] LAST_CNT = SW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [SW-1:0]   smp_cnt, smp_cnt_nx;
    logic [3:0]      bit_cnt, bit_cnt_nx;
    logic [7:0]      shift_reg, shift_reg_nx;
    logic            armed, armed_nx;
    logic            load;
    logic            rd;
    logic            rxd_m, rxd_s;

    // Bring the asynchronous line into the clk domain; idle level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // Frame-tracking state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            smp_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            armed     <= 1'b0;
        end else begin
            state     <= state_nx;
            smp_cnt   <= smp_cnt_nx;
            bit_cnt   <= bit_cnt_nx;
            shift_reg <= shift_reg_nx;
            armed     <= armed_nx;
        end
    end

    // Next-state logic; everything advances only on baud ticks.
    always_comb begin
        state_nx     = state;
        smp_cnt_nx   = smp_cnt;
        bit_cnt_nx   = bit_cnt;
        shift_reg_nx = shift_reg;
        armed_nx     = armed;
        load         = 1'b0;
        if (brg_rx_en) begin
            case (state)
                IDLE: begin
                    // Only a high-to-low transition seen after arming counts as a start.
                    if (rxd_s) begin
                        armed_nx = 1'b1;
                    end else if (armed) begin
                        state_nx   = START;
                        smp_cnt_nx = '0;
                        bit_cnt_nx = '0;
                    end
                end
                START: begin
                    if (smp_cnt == MID_CNT) begin
                        // Line back high at mid start bit means a glitch.
                        state_nx   = rxd_s ? IDLE : DATA;
                        smp_cnt_nx = '0;
                        bit_cnt_nx = '0;
                    end else begin
                        smp_cnt_nx = smp_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (smp_cnt == LAST_CNT) begin
                        shift_reg_nx = {rxd_s, shift_reg[7:1]};
                        smp_cnt_nx   = '0;
                        if (bit_cnt == 4'd7) begin
                            state_nx   = STOP;
                            bit_cnt_nx = '0;
                        end else begin
                            bit_cnt_nx = bit_cnt + 4'd1;
                        end
                    end else begin
                        smp_cnt_nx = smp_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (smp_cnt == LAST_CNT) begin
                        load       = 1'b1;
                        state_nx   = IDLE;
                        smp_cnt_nx = '0;
                        bit_cnt_nx = '0;
                    end else begin
                        smp_cnt_nx = smp_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx   = IDLE;
                    smp_cnt_nx = '0;
                    bit_cnt_nx = '0;
                end
            endcase
        end
    end

    assign rd = iocs & iorw & (ioaddr == 2'b00);

    // Bus-visible registers: a STOP load beats a same-cycle read, and that read suppresses overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_buf <= 8'h00;
            rda    <= 1'b0;
            fe     <= 1'b0;
            oe     <= 1'b0;
        end else begin
            if (load) begin
                rx_buf <= shift_reg;
            end
            rda <= load | (rda & ~rd);
            fe  <= load ? ~rxd_s : (fe & ~rd);
            oe  <= ~rd & (oe | (load & rda));
        end
    end

endmodule

// File: tb/tb_receive.sv
// Bench for receive: drives 8N1 frames at 16x with randomly spaced ticks and bus noise.
// Expected register contents come from a per-frame model of the bus-visible registers.
// Every comparison goes through chk; one summary line at the end.
module tb_receive;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       brg_rx_en;
    logic       rxd;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] rx_buf;
    logic       rda;
    logic       fe;
    logic       oe;

    int n_chk = 0;
    int n_err = 0;

    // Reference view of the processor-visible registers.
    logic [7:0] m_buf;
    logic       m_rda, m_fe, m_oe;

    receive #(.OVERSAMPLE(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .brg_rx_en (brg_rx_en),
        .rxd       (rxd),
        .iocs      (iocs),
        .iorw      (iorw),
        .ioaddr    (ioaddr),
        .rx_buf    (rx_buf),
        .rda       (rda),
        .fe        (fe),
        .oe        (oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_buf"}, 32'(rx_buf), 32'(m_buf));
        chk({tag, "_rda"}, 32'(rda), 32'(m_rda));
        chk({tag, "_fe"},  32'(fe),  32'(m_fe));
        chk({tag, "_oe"},  32'(oe),  32'(m_oe));
    endtask

    // One baud tick after a random gap; non-read bus traffic rides along unless a read is requested.
    task automatic tick(input bit rd_now);
        logic w;
        repeat (2 + $urandom_range(0, 2)) @(negedge clk);
        brg_rx_en = 1'b1;
        if (rd_now) begin
            iocs   = 1'b1;
            iorw   = 1'b1;
            ioaddr = 2'b00;
        end else begin
            w      = 1'($urandom);
            iocs   = 1'($urandom);
            iorw   = w;
            ioaddr = w ? 2'(1 + $urandom_range(0, 2)) : 2'($urandom);
        end
        @(negedge clk);
        brg_rx_en = 1'b0;
        iocs      = 1'b0;
        iorw      = 1'b0;
        ioaddr    = 2'b00;
    endtask

    task automatic bus_read(input string tag);
        @(negedge clk);
        iocs   = 1'b1;
        iorw   = 1'b1;
        ioaddr = 2'b00;
        chk({tag, "_rdbuf"}, 32'(rx_buf), 32'(m_buf));
        @(negedge clk);
        iocs   = 1'b0;
        iorw   = 1'b0;
        m_rda  = 1'b0;
        m_fe   = 1'b0;
        m_oe   = 1'b0;
        check_all({tag, "_clr"});
    endtask

    // Full frame, 16 ticks per bit. The stop sample is the 9th tick of the stop bit
    // (152 ticks after the start-detect tick, which is the first tick after the edge).
    task automatic send_frame(input string tag, input logic [7:0] d, input bit stop, input bit rd_at_stop);
        rxd = 1'b0;
        repeat (16) tick(1'b0);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (16) tick(1'b0);
        end
        rxd = stop;
        repeat (8) tick(1'b0);
        chk({tag, "_pre_rda"}, 32'(rda), 32'(m_rda));
        tick(rd_at_stop);
        m_oe  = rd_at_stop ? 1'b0 : (m_oe | m_rda);
        m_rda = 1'b1;
        m_fe  = ~stop;
        m_buf = d;
        check_all(tag);
        repeat (7) tick(1'b0);
        rxd = 1'b1;
        repeat (24) tick(1'b0);
        check_all({tag, "_hold"});
    endtask

    initial begin
        logic [7:0] d;
        bit         stop;
        int         mode;

        rst_n = 1'b0; brg_rx_en = 1'b0; rxd = 1'b1;
        iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
        m_buf = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_oe = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        repeat (20) tick(1'b0);

        // Clean frame, then read.
        send_frame("a5", 8'hA5, 1'b1, 1'b0);
        bus_read("a5");

        // Glitch shorter than half a bit is rejected.
        rxd = 1'b0;
        repeat (4) tick(1'b0);
        rxd = 1'b1;
        repeat (20) tick(1'b0);
        check_all("glitch");
        send_frame("5a", 8'h5A, 1'b1, 1'b0);
        bus_read("5a");

        // Framing error.
        send_frame("3c", 8'h3C, 1'b0, 1'b0);
        bus_read("3c");

        // Overrun, then the same pair with a read on the second load.
        send_frame("ov11", 8'h11, 1'b1, 1'b0);
        send_frame("ov22", 8'h22, 1'b1, 1'b0);
        bus_read("ov");
        send_frame("nr11", 8'h11, 1'b1, 1'b0);
        send_frame("nr22", 8'h22, 1'b1, 1'b1);
        bus_read("nr");

        // Boundary data.
        send_frame("b00", 8'h00, 1'b1, 1'b0);
        bus_read("b00");
        send_frame("b80", 8'h80, 1'b1, 1'b0);
        bus_read("b80");

        // Reset mid-frame with the line low, then hold low: no frame until it idles high.
        send_frame("pre_rst", 8'h77, 1'b1, 1'b0);
        rxd = 1'b0;
        repeat (40) tick(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        m_buf = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_oe = 1'b0;
        #1;
        check_all("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) tick(1'b0);
        check_all("lowhold");
        rxd = 1'b1;
        repeat (20) tick(1'b0);
        send_frame("ff", 8'hFF, 1'b1, 1'b0);
        bus_read("ff");

        // Random frames with random read placement.
        for (int n = 0; n < 20; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            mode = $urandom_range(0, 2);
            if (mode == 1) bus_read("rnd_pre");
            send_frame("rnd", d, stop, mode == 2);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/receive.md
# receive

UART receiver: deserializes the 8N1 serial line into bytes for the processor bus. It is the receive-side counterpart of the transmit stage and shares its 16x baud-rate enable source (`brg_rx_en`) and its `iocs/iorw/ioaddr` bus handshake. It detects and validates the start bit, samples each bit at mid-bit, and holds the received byte until the processor reads it. It also reports framing and overrun errors.

## Interface
- `OVERSAMPLE`, 16: `brg_rx_en` ticks per bit period; must be a power of 2 and ≥ 8.
- `clk`  input  1  system clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `brg_rx_en`  input  1  one-cycle pulse at `OVERSAMPLE` × baud, from the baud-rate generator.
- `rxd`  input  1  serial line; asynchronous to `clk`; idle high.
- `iocs`  input  1  bus chip select.
- `iorw`  input  1  1 = read, 0 = write.
- `ioaddr`  input  2  bus register address; 2'b00 = data register.
- `rx_buf`  output  8  last received byte.
- `rda`  output  1  receive data available.
- `fe`  output  1  framing error (stop bit sampled low) for the byte in `rx_buf`.
- `oe`  output  1  overrun: a byte was overwritten before it was read.

## Operation
- **Synchronizer:** 2-flop synchronizer on `rxd`, producing `rxd_s`. Both flops reset to 1.
- **Counters:**
  - `smp_cnt` (log2 `OVERSAMPLE` bits) counts `brg_rx_en` ticks.
  - `bit_cnt` (4 bits) counts data bits.
  - Both are cleared on each state entry.
  - All sampling happens only on cycles where `brg_rx_en` = 1.
- **Armed flag:**
  - Cleared by reset.
  - Set in IDLE on a tick with `rxd_s` = 1.
  - A start bit is accepted only when armed, so a line held low through reset is not taken as a frame.
- **States:**
  - IDLE: on a tick with armed and `rxd_s` = 0 → START.
  - START: on the tick where `smp_cnt` = `OVERSAMPLE`/2 − 1 (mid start bit):
    - `rxd_s` = 0 → DATA.
    - `rxd_s` = 1 → false start, return to IDLE (no flags change).
  - DATA: on the tick where `smp_cnt` = `OVERSAMPLE` − 1:
    - shift `rxd_s` into the MSB of `shift_reg` (LSB-first line order) and increment `bit_cnt`.
    - After the 8th bit → STOP.
  - STOP: on the tick where `smp_cnt` = `OVERSAMPLE` − 1:
    - `rx_buf` ← `shift_reg`; `rda` ← 1; `fe` ← ~`rxd_s`.
    - `oe` ← 1 if `rda` was already 1 and no read occurs this cycle.
    - → IDLE. Armed stays set, so the next start edge is caught right after the stop-bit mid-sample.
- **Processor read:** `iocs` & `iorw` & `ioaddr` == 2'b00.
  - The read sees the current `rx_buf`, `rda`, `fe` and `oe` combinationally.
  - At the next edge it clears `rda`, `fe` and `oe`.
- **Read and STOP load in the same cycle:**
  - The load wins: `rda` = 1, and `fe` takes the new frame's value.
  - `oe` is not set, because the old byte was consumed.
- **Writes:** writes and other addresses are ignored.
- **`brg_rx_en` pauses:** a missing tick only delays the sampling points. There is no timeout.

## Timing
- **Reset values:** `rx_buf` = 8'h00, `rda` = 0, `fe` = 0, `oe` = 0, state IDLE, `smp_cnt` = 0, `bit_cnt` = 0, armed = 0.
- **Start detection:** start is recognized at most 1 tick plus 2 clk cycles after the falling edge on `rxd`.
- **Latency:**
  - `rda` rises on the clk edge that processes the STOP sample tick.
  - That tick is `OVERSAMPLE`/2 + 9 × `OVERSAMPLE` ticks after the start-detect tick (152 ticks at 16x).
- **Output holding:** `rx_buf` is stable from the `rda` rising edge until the next STOP load.
- **Reset mid-frame:** asynchronous return to IDLE with all outputs at reset values. The partial frame is discarded, and the block rearms only after `rxd_s` is sampled high.
- **Registered outputs:** all outputs are registered. There is no combinational path from `rxd` to any output.

## Test plan
- **Clean frame:** frame 0xA5 at 16x, stop = 1 → `rx_buf` = 8'hA5, `rda` = 1, `fe` = 0, `oe` = 0. A read cycle (`iocs` = 1, `iorw` = 1, `ioaddr` = 00) then gives `rda` = 0 on the next edge.
- **Glitch:** `rxd` low for 4 ticks, then high → no state beyond START, `rda` stays 0, next valid frame 0x5A received correctly.
- **Framing error:** frame 0x3C with stop bit driven 0 → `rx_buf` = 8'h3C, `rda` = 1, `fe` = 1. A read clears `fe`.
- **Overrun:** back-to-back 0x11 then 0x22, no read → `rx_buf` = 8'h22, `rda` = 1, `oe` = 1. A read in the same cycle as the second STOP load instead gives `oe` = 0, `rda` = 1.
- **Reset mid-frame:** assert `rst_n` low mid-DATA with `rxd` low → outputs reset. `rxd` held low for 40 ticks → no frame. Then idle high plus frame 0xFF → `rx_buf` = 8'hFF, `fe` = 0.
- **Boundary data:** frames 0x00 and 0x80 each received exactly. This checks LSB-first order and the 8th-bit boundary.
